spi_responder: RTL

SPI_RESPONDER -- requirements
Module: spi_responder

---
 rtl/spi_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spi_responder.sv
// SPI mode-3 byte responder: synchronises the external SPI pins into MasterCLK,
// receives MOSI bytes and returns a one-byte-buffered transmit stream on MISO.
// Optional sticky underrun flag: define SPI_RESPONDER_UNDERRUN_EN.
module spi_responder (
    input  logic       MasterCLK,
    input  logic       Reset_n,
    input  logic       SPI_CLK,
    input  logic       SPI_CS_n,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    input  logic [7:0] TxData,
    input  logic       TxLoad,
    output logic       TxReady,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       Busy
`ifdef SPI_RESPONDER_UNDERRUN_EN
    ,
    output logic       TxUnderrun
`endif
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    logic          r_sclk_s1, r_sclk_s2, r_sclk_prev;
    logic          r_cs_s1, r_cs_s2, r_cs_prev;
    logic          r_mosi_s1, r_mosi_s2;
    logic [CW-1:0] r_cnt;
    logic [DW-2:0] r_rx_shift;
    logic [DW-1:0] r_rx_data;
    logic          r_rx_valid;
    logic [DW-1:0] r_tx_shift;
    logic [DW-1:0] r_hold;
    logic          r_tx_ready;
    logic          r_miso;
    logic          r_busy;

    logic          w_cs_fall, w_cs_rise, w_active;
    logic          w_rise, w_fall, w_wrap, w_load_evt, w_tx_take;
    logic [CW-1:0] w_bit_idx;
    logic [DW-1:0] w_next_byte;

    // Two-flop synchronisers plus a history flop for edge detection; idle levels on reset.
    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sclk_s1   <= 1'b1;
            r_sclk_s2   <= 1'b1;
            r_sclk_prev <= 1'b1;
            r_cs_s1     <= 1'b1;
            r_cs_s2     <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_mosi_s1   <= 1'b1;
            r_mosi_s2   <= 1'b1;
        end else begin
            r_sclk_s1   <= SPI_CLK;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_prev <= r_sclk_s2;
            r_cs_s1     <= SPI_CS_n;
            r_cs_s2     <= r_cs_s1;
            r_cs_prev   <= r_cs_s2;
            r_mosi_s1   <= SPI_MOSI;
            r_mosi_s2   <= r_mosi_s1;
        end
    end

    assign w_active   = ~r_cs_s2;
    assign w_cs_fall  = ~r_cs_s2 & r_cs_prev;
    assign w_cs_rise  = r_cs_s2 & ~r_cs_prev;
    assign w_rise     = w_active & r_sclk_s2 & ~r_sclk_prev;
    assign w_fall     = w_active & ~r_sclk_s2 & r_sclk_prev;
    assign w_wrap     = w_rise & (r_cnt == CW'(DW - 1));
    assign w_load_evt = w_cs_fall | w_wrap;
    assign w_tx_take  = TxLoad & r_tx_ready;
    assign w_bit_idx  = CW'(DW - 1) - r_cnt;

    // Byte entering the transmit shifter on a load event: coinciding TxLoad wins, 0xFF on underrun.
    always_comb begin
        w_next_byte = {DW{1'b1}};
        if (w_tx_take) begin
            w_next_byte = TxData;
        end else if (!r_tx_ready) begin
            w_next_byte = r_hold;
        end
    end

    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt      <= '0;
            r_rx_shift <= '1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_wrap;
            if (w_cs_fall || w_cs_rise) begin
                r_cnt <= '0;
            end else if (w_rise) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_rise) begin
                r_rx_shift <= {r_rx_shift[DW-3:0], r_mosi_s2};
            end
            if (w_wrap) begin
                r_rx_data <= {r_rx_shift, r_mosi_s2};
            end
        end
    end

    // Holding register, transmit shifter and MISO driver.
    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tx_shift <= '1;
            r_hold     <= '0;
            r_tx_ready <= 1'b1;
            r_miso     <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= ~r_cs_s1;
            if (w_cs_rise) begin
                r_tx_shift <= '1;
            end else if (w_load_evt) begin
                r_tx_shift <= w_next_byte;
            end
            if (w_load_evt && !w_tx_take) begin
                r_tx_ready <= 1'b1;
            end else if (w_tx_take && !w_load_evt) begin
                r_hold     <= TxData;
                r_tx_ready <= 1'b0;
            end
            if (r_cs_s2) begin
                r_miso <= 1'b1;
            end else if (w_cs_fall) begin
                r_miso <= w_next_byte[DW-1];
            end else if (w_fall) begin
                r_miso <= r_tx_shift[w_bit_idx];
            end
        end
    end

`ifdef SPI_RESPONDER_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_underrun <= 1'b0;
        end else if (w_cs_rise) begin
            r_underrun <= 1'b0;
        end else if (w_load_evt && r_tx_ready && !TxLoad) begin
            r_underrun <= 1'b1;
        end
    end

    assign TxUnderrun = r_underrun;
`endif

    assign SPI_MISO = r_miso;
    assign TxReady  = r_tx_ready;
    assign RxData   = r_rx_data;
    assign RxValid  = r_rx_valid;
    assign Busy     = r_busy;

endmodule
